// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: sequencer that drives the select lines of an external 4:1 mux.
// On start it visits every enabled channel in ascending order, holds each select for
// DWELL cycles, captures mux_out on the last cycle of each dwell, and emits a one-cycle
// valid pulse once the snapshot is complete.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - scan request, only looked at while idle
//   ch_en    - channel enable mask, captured when start is accepted
//   mux_out  - output of the mux being scanned (synchronous to clk)
//   S1, S0   - registered mux select, {S1,S0} = channel index
//   sample_q - snapshot, bit i = mux_out captured while channel i was selected
//   valid    - one-cycle pulse: sample_q holds a completed scan
//   busy     - high while channels are being dwelt on
module mux4_scan_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] ch_en,
    input  logic       mux_out,
    output logic       S1,
    output logic       S0,
    output logic [3:0] sample_q,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDwell,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      sample_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [1:0]      lowest_sel;
    logic [1:0]      next_sel;
    logic            has_next;

    // Lowest enabled channel in the incoming mask (used on start acceptance).
    always_comb begin
        lowest_sel = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            if (ch_en[i]) begin
                lowest_sel = 2'(i);
            end
        end
    end

    // Nearest enabled channel strictly above the current one; no wrap-around.
    always_comb begin
        has_next = 1'b0;
        next_sel = sel_q;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                has_next = 1'b1;
                next_sel = 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        mask_d   = mask_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d   = ch_en;
                    sample_d = 4'b0000;
                    cnt_d    = '0;
                    if (ch_en != 4'b0000) begin
                        sel_d   = lowest_sel;
                        state_d = StDwell;
                    end else begin
                        // Nothing to scan: select stays put, report completion at once.
                        state_d = StDone;
                    end
                end
            end
            StDwell: begin
                if (cnt_q == CntLast) begin
                    sample_d[sel_q] = mux_out;
                    cnt_d           = '0;
                    if (has_next) begin
                        sel_d = next_sel;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sel_q    <= 2'b00;
            mask_q   <= 4'b0000;
            sample_q <= 4'b0000;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
        end
    end

    assign S1    = sel_q[1];
    assign S0    = sel_q[0];
    assign valid = (state_q == StDone);
    assign busy  = (state_q == StDwell);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed testbench for mux4_scan_ctrl with DWELL=4 and a behavioural 4:1 mux.
module tb_mux4_scan_ctrl;

    localparam int DW = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] ch_en;
    logic       mux_out;
    logic       S1;
    logic       S0;
    logic [3:0] sample_q;
    logic       valid;
    logic       busy;
    logic [3:0] mux_in;

    int checks;
    int errors;

    mux4_scan_ctrl #(.DWELL(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ch_en    (ch_en),
        .mux_out  (mux_out),
        .S1       (S1),
        .S0       (S0),
        .sample_q (sample_q),
        .valid    (valid),
        .busy     (busy)
    );

    // The mux under control: combinational from the registered selects.
    assign mux_out = mux_in[{S1, S0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start  = 1'($urandom);
            ch_en  = 4'($urandom);
            mux_in = 4'($urandom);
        end
        #1;
        checks++;
        if ({S1, S0, sample_q, valid, busy} !== 8'b00_0000_0_0) begin
            errors++;
            $display("FAIL reset_hold got sel=%b sample=%b valid=%b busy=%b want 00 0000 0 0",
                     {S1, S0}, sample_q, valid, busy);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({S1, S0, sample_q, valid, busy} !== 8'b00_0000_0_0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got sel=%b sample=%b valid=%b busy=%b want 00 0000 0 0",
                         i, {S1, S0}, sample_q, valid, busy);
            end
        end
    endtask

    task automatic test_full_scan();
        @(negedge clk);
        mux_in = 4'b0101;
        ch_en  = 4'b1111;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4 * DW; k++) begin
            checks++;
            if ({S1, S0, busy, valid} !== {2'(k / DW), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL full_step k=%0d got sel=%b busy=%b valid=%b want sel=%b busy=1 valid=0",
                         k, {S1, S0}, busy, valid, 2'(k / DW));
            end
            @(negedge clk);
        end
        checks++;
        if ({valid, busy, sample_q, S1, S0} !== 8'b1_0_0101_11) begin
            errors++;
            $display("FAIL full_done got valid=%b busy=%b sample=%b sel=%b want 1 0 0101 11",
                     valid, busy, sample_q, {S1, S0});
        end
        @(negedge clk);
        checks++;
        if ({valid, busy, sample_q} !== 6'b0_0_0101) begin
            errors++;
            $display("FAIL full_after got valid=%b busy=%b sample=%b want 0 0 0101",
                     valid, busy, sample_q);
        end
    endtask

    task automatic test_sparse();
        @(negedge clk);
        mux_in = 4'b1011;
        ch_en  = 4'b1010;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2 * DW; k++) begin
            checks++;
            if ({S1, S0, busy, valid} !== {((k < DW) ? 2'b01 : 2'b11), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL sparse_step k=%0d got sel=%b busy=%b valid=%b want sel=%b busy=1 valid=0",
                         k, {S1, S0}, busy, valid, (k < DW) ? 2'b01 : 2'b11);
            end
            @(negedge clk);
        end
        checks++;
        if ({valid, busy, sample_q, S1, S0} !== 8'b1_0_1010_11) begin
            errors++;
            $display("FAIL sparse_done got valid=%b busy=%b sample=%b sel=%b want 1 0 1010 11",
                     valid, busy, sample_q, {S1, S0});
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL sparse_pulse got valid=%b want 0", valid);
        end
    endtask

    // Runs after the sparse scan, so the select is left at 11.
    task automatic test_empty();
        @(negedge clk);
        mux_in = 4'b1111;
        ch_en  = 4'b0000;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({valid, busy, sample_q, S1, S0} !== 8'b1_0_0000_11) begin
            errors++;
            $display("FAIL empty_done got valid=%b busy=%b sample=%b sel=%b want 1 0 0000 11",
                     valid, busy, sample_q, {S1, S0});
        end
        @(negedge clk);
        checks++;
        if ({valid, busy, sample_q, S1, S0} !== 8'b0_0_0000_11) begin
            errors++;
            $display("FAIL empty_after got valid=%b busy=%b sample=%b sel=%b want 0 0 0000 11",
                     valid, busy, sample_q, {S1, S0});
        end
    endtask

    task automatic test_ignored();
        int pulses;
        pulses = 0;
        @(negedge clk);
        mux_in = 4'b0101;
        ch_en  = 4'b1111;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4 * DW; k++) begin
            if (valid) pulses++;
            checks++;
            if ({S1, S0, busy} !== {2'(k / DW), 1'b1}) begin
                errors++;
                $display("FAIL ignored_step k=%0d got sel=%b busy=%b want sel=%b busy=1",
                         k, {S1, S0}, busy, 2'(k / DW));
            end
            if (k == 5) begin
                start = 1'b1;
                ch_en = 4'b0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        if (valid) pulses++;
        checks++;
        if ({valid, busy, sample_q, S1, S0} !== 8'b1_0_0101_11) begin
            errors++;
            $display("FAIL ignored_done got valid=%b busy=%b sample=%b sel=%b want 1 0 0101 11",
                     valid, busy, sample_q, {S1, S0});
        end
        // Start seen during DONE must not launch a new scan.
        start = 1'b1;
        ch_en = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (valid) pulses++;
            checks++;
            if ({valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL ignored_done_start cyc=%0d got valid=%b busy=%b want 0 0",
                         k, valid, busy);
            end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignored_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mux_in = 4'b0101;
        ch_en  = 4'b1111;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Channel 2 starts two dwells in; two more edges take cnt to 2.
        repeat (2 * DW + 2) @(negedge clk);
        checks++;
        if ({S1, S0, busy, sample_q} !== 7'b10_1_0001) begin
            errors++;
            $display("FAIL midscan_pre got sel=%b busy=%b sample=%b want 10 1 0001",
                     {S1, S0}, busy, sample_q);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({S1, S0, sample_q, valid, busy} !== 8'b00_0000_0_0) begin
            errors++;
            $display("FAIL midscan_async got sel=%b sample=%b valid=%b busy=%b want 00 0000 0 0",
                     {S1, S0}, sample_q, valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({S1, S0, sample_q, valid, busy} !== 8'b00_0000_0_0) begin
                errors++;
                $display("FAIL midscan_idle cyc=%0d got sel=%b sample=%b valid=%b busy=%b want 00 0000 0 0",
                         k, {S1, S0}, sample_q, valid, busy);
            end
        end
        test_full_scan();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        ch_en  = 4'b0000;
        mux_in = 4'b0000;
        test_reset();
        test_full_scan();
        test_sparse();
        test_empty();
        test_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
